// File: rtl/pipe_skid_stage.sv
// Pipeline stage register carrying an opaque payload under a valid/ready
// handshake. With SKID=1 a second holding register lets up_ready_o come
// straight from a flop, so no combinational path runs from dn_ready_i back
// upstream. With SKID=0 it is a single register whose ready is combinational.
//
// State table (the state is the number of beats held, driven onto occ_o):
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_EMPTY | nothing held, dn_valid_o=0
//   ST_ONE   | one beat in the main register, presented downstream
//   ST_FULL  | main register presented, a younger beat waits in the skid
//            | register (SKID=1 only), up_ready_o=0
module pipe_skid_stage #(
    parameter int DATA_W  = 128,
    parameter int SKID    = 1,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               up_valid_i,
    output logic               up_ready_o,
    input  logic [DATA_W-1:0]  up_data_i,
    output logic               dn_valid_o,
    input  logic               dn_ready_i,
    output logic [DATA_W-1:0]  dn_data_o,
    output logic [1:0]         occ_o,
    output logic [STALL_W-1:0] stall_cnt_o,
    input  logic               stat_clr_i
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  main_data_q, main_data_d;
    logic [DATA_W-1:0]  skid_data_q, skid_data_d;
    logic               up_ready_q, up_ready_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    logic dn_valid;
    logic up_acc;
    logic dn_acc;

    assign dn_valid = (state_q != ST_EMPTY);

    // With no skid register ready must see the downstream accept in the same
    // cycle; otherwise ready is the registered "not going full" flag.
    assign up_ready_o = (SKID != 0) ? up_ready_q : (!dn_valid || dn_ready_i);

    // A beat arriving together with a flush is squashed, never accepted.
    assign up_acc = up_valid_i && up_ready_o && !flush_i;
    assign dn_acc = dn_valid && dn_ready_i;

    assign dn_valid_o  = dn_valid;
    assign dn_data_o   = main_data_q;
    assign occ_o       = state_q;
    assign stall_cnt_o = stall_cnt_q;

    // Next-state, data-register and ready computation; flush overrides all.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (up_acc) begin
                        state_d     = ST_ONE;
                        main_data_d = up_data_i;
                    end
                end
                ST_ONE: begin
                    if (up_acc && dn_acc) begin
                        main_data_d = up_data_i;
                    end else if (up_acc) begin
                        // Only reachable with SKID=1: SKID=0 ready implies dn_acc here.
                        state_d     = ST_FULL;
                        skid_data_d = up_data_i;
                    end else if (dn_acc) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (dn_acc) begin
                        state_d     = ST_ONE;
                        main_data_d = skid_data_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        up_ready_d = (state_d != ST_FULL);
    end

    // Saturating back-pressure counter; clear wins, flush does not touch it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stat_clr_i) begin
            stall_cnt_d = '0;
        end else if (dn_valid && !dn_ready_i && (stall_cnt_q != {STALL_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(STALL_W-1){1'b0}}, 1'b1};
        end
    end

    // State, payload, ready and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            skid_data_q <= '0;
            up_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
            up_ready_q  <= up_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
